// File: rtl/mem_port_arbiter_if.sv
// Requester-side command/response bundle for one port of mem_port_arbiter.
// master = requester (CPU dBus or loader), slave = arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_WL = 13,
  parameter int DATA_WL = 32,
  parameter int NB_COL  = 4
);
  logic               valid;
  logic               ready;
  logic               wr;
  logic [ADDR_WL-1:0] addr;
  logic [DATA_WL-1:0] wdata;
  logic [NB_COL-1:0]  be;
  logic               rsp_valid;
  logic [DATA_WL-1:0] rdata;

  modport master (
    output valid, wr, addr, wdata, be,
    input  ready, rsp_valid, rdata
  );

  modport slave (
    input  valid, wr, addr, wdata, be,
    output ready, rsp_valid, rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the RAM data port: fixed priority to m0 with a
// starvation limit for m1, plus a lock handshake giving m1 exclusive access.
//
// state  | meaning
// NORMAL | both requesters eligible, m0 preferred unless m1 has waited MAX_WAIT
// DRAIN  | one cycle: m0 blocked so its last read response can complete
// LOCKED | lock_ack high, only m1 served
module mem_port_arbiter #(
  parameter int ADDR_WL  = 13,
  parameter int DATA_WL  = 32,
  parameter int NB_COL   = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic               clk,
  input  logic               resetn,
  mem_port_arbiter_if.slave  m0,
  mem_port_arbiter_if.slave  m1,
  input  logic               lock_req,
  output logic               lock_ack,
  output logic [ADDR_WL-1:0] mem_addr,
  output logic [NB_COL-1:0]  mem_we,
  output logic [DATA_WL-1:0] mem_din,
  input  logic [DATA_WL-1:0] mem_dout
);

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [7:0]         r_wait_cnt;
  logic               r_lock_ack;
  logic               r_rsp_vld;
  logic               r_rsp_tag;
  logic [ADDR_WL-1:0] r_addr_hold;

  logic w_m0_elig;
  logic w_m0_req;
  logic w_sel_m1;
  logic w_m0_acc;
  logic w_m1_acc;
  logic w_acc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_NORMAL;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_m0_elig   = 1'b0;
    case (r_state)
      ST_NORMAL: begin
        w_m0_elig = 1'b1;
        if (lock_req) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN:  w_state_nxt = lock_req ? ST_LOCKED : ST_NORMAL;
      ST_LOCKED: if (!lock_req) w_state_nxt = ST_NORMAL;
      default:   w_state_nxt = ST_NORMAL;
    endcase
  end

  // m1 wins whenever m0 is not competing, or once it has been passed over MAX_WAIT times
  assign w_m0_req = m0.valid && w_m0_elig;
  assign w_sel_m1 = m1.valid && (!w_m0_req || (r_wait_cnt == LP_MAX_WAIT));
  assign w_m0_acc = w_m0_req && !w_sel_m1;
  assign w_m1_acc = w_sel_m1;
  assign w_acc    = w_m0_acc || w_m1_acc;

  assign m0.ready = w_m0_acc;
  assign m1.ready = w_m1_acc;

  assign mem_addr = w_acc ? (w_sel_m1 ? m1.addr : m0.addr) : r_addr_hold;
  assign mem_din  = w_sel_m1 ? m1.wdata : m0.wdata;

  always_comb begin
    mem_we = '0;
    if (w_m1_acc && m1.wr)      mem_we = m1.be;
    else if (w_m0_acc && m0.wr) mem_we = m0.be;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wait_cnt  <= 8'd0;
      r_lock_ack  <= 1'b0;
      r_rsp_vld   <= 1'b0;
      r_rsp_tag   <= 1'b0;
      r_addr_hold <= '0;
    end else begin
      if (r_state != ST_LOCKED) begin
        if (w_m1_acc || !m1.valid)
          r_wait_cnt <= 8'd0;
        else if (w_m0_acc && (r_wait_cnt != LP_MAX_WAIT))
          r_wait_cnt <= r_wait_cnt + 8'd1;
      end
      r_lock_ack <= (w_state_nxt == ST_LOCKED);
      r_rsp_vld  <= (w_m0_acc && !m0.wr) || (w_m1_acc && !m1.wr);
      r_rsp_tag  <= w_m1_acc;
      if (w_acc) r_addr_hold <= mem_addr;
    end
  end

  assign lock_ack     = r_lock_ack;
  assign m0.rsp_valid = r_rsp_vld && !r_rsp_tag;
  assign m1.rsp_valid = r_rsp_vld && r_rsp_tag;
  assign m0.rdata     = mem_dout;
  assign m1.rdata     = mem_dout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter with a write-first 1-cycle RAM model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        lock_req;
  logic        lock_ack;
  logic [12:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WL(13), .DATA_WL(32), .NB_COL(4)) m0_if ();
  mem_port_arbiter_if #(.ADDR_WL(13), .DATA_WL(32), .NB_COL(4)) m1_if ();

  mem_port_arbiter #(.ADDR_WL(13), .DATA_WL(32), .NB_COL(4), .MAX_WAIT(8)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .m0       (m0_if),
    .m1       (m1_if),
    .lock_req (lock_req),
    .lock_ack (lock_ack),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  // RAM model: untouched words read back a fixed pattern, writes are byte-merged
  bit          written [8192];
  logic [31:0] ram     [8192];

  function automatic logic [31:0] base(input logic [12:0] a);
    case (a)
      13'h010: return 32'hDEADBEEF;
      13'h005: return 32'h11223344;
      default: return 32'h1000_0000 + {19'd0, a};
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (we[b]) r[b*8 +: 8] = din[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    mem_dout <= merge(written[mem_addr] ? ram[mem_addr] : base(mem_addr), mem_din, mem_we);
    if (mem_we != 4'h0) begin
      ram[mem_addr]     <= merge(written[mem_addr] ? ram[mem_addr] : base(mem_addr),
                                 mem_din, mem_we);
      written[mem_addr] <= 1'b1;
    end
  end

  typedef struct {
    logic        m0v, m0w; logic [12:0] m0a; logic [3:0] m0be; logic [31:0] m0d;
    logic        m1v, m1w; logic [12:0] m1a; logic [3:0] m1be; logic [31:0] m1d;
    logic        lk, rst;
    logic        e_r0, e_r1; logic [3:0] e_we; logic [12:0] e_addr;
    logic        e_v0, e_v1; logic [31:0] e_rd; logic e_ack;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input int idx, input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL vec %0d %s: got %h expected %h", idx, nm, act, exp);
    end
  endtask

  // Both requesters hold reads continuously; m1 must win every 9th cycle.
  task automatic add_contend(input int n);
    logic prev_m1;
    logic have_prev;
    logic win1;
    have_prev = 1'b0;
    prev_m1   = 1'b0;
    for (int k = 0; k < n; k++) begin
      win1 = ((k % 9) == 8);
      vq.push_back(vec_t'{1,0,13'h020,4'h0,32'h0, 1,0,13'h021,4'h0,32'h0, 0,0,
                          !win1, win1, 4'h0, win1 ? 13'h021 : 13'h020,
                          have_prev && !prev_m1, have_prev && prev_m1,
                          prev_m1 ? 32'h1000_0021 : 32'h1000_0020, 0});
      have_prev = 1'b1;
      prev_m1   = win1;
    end
    vq.push_back(vec_t'{0,0,13'h0,4'h0,32'h0, 0,0,13'h0,4'h0,32'h0, 0,0,
                        0,0,4'h0, prev_m1 ? 13'h021 : 13'h020, !prev_m1, prev_m1,
                        prev_m1 ? 32'h1000_0021 : 32'h1000_0020, 0});
  endtask

  task automatic apply(input int idx, input vec_t v);
    @(posedge clk);
    #1;
    m0_if.valid = v.m0v; m0_if.wr = v.m0w; m0_if.addr = v.m0a; m0_if.be = v.m0be;
    m0_if.wdata = v.m0d;
    m1_if.valid = v.m1v; m1_if.wr = v.m1w; m1_if.addr = v.m1a; m1_if.be = v.m1be;
    m1_if.wdata = v.m1d;
    lock_req    = v.lk;
    if (v.rst) begin
      #1 resetn = 1'b0;
      #1 resetn = 1'b1;
      #1;
    end else begin
      #2;
    end
    chk(idx, "m0_ready",     {31'd0, m0_if.ready},     {31'd0, v.e_r0});
    chk(idx, "m1_ready",     {31'd0, m1_if.ready},     {31'd0, v.e_r1});
    chk(idx, "mem_we",       {28'd0, mem_we},          {28'd0, v.e_we});
    chk(idx, "mem_addr",     {19'd0, mem_addr},        {19'd0, v.e_addr});
    chk(idx, "lock_ack",     {31'd0, lock_ack},        {31'd0, v.e_ack});
    chk(idx, "m0_rsp_valid", {31'd0, m0_if.rsp_valid}, {31'd0, v.e_v0});
    chk(idx, "m1_rsp_valid", {31'd0, m1_if.rsp_valid}, {31'd0, v.e_v1});
    if (v.e_v0) chk(idx, "m0_rdata", m0_if.rdata, v.e_rd);
    if (v.e_v1) chk(idx, "m1_rdata", m1_if.rdata, v.e_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // stimulus: m0{v,wr,addr,be,wdata} m1{...} lock rst | expect: r0 r1 we addr v0 v1 rdata ack
    vq.push_back('{0,0,13'h000,4'h0,32'h0, 0,0,13'h000,4'h0,32'h0, 0,0, 0,0,4'h0,13'h000,0,0,32'h0,0});
    vq.push_back('{1,0,13'h010,4'h0,32'h0, 0,0,13'h000,4'h0,32'h0, 0,0, 1,0,4'h0,13'h010,0,0,32'h0,0});
    vq.push_back('{0,0,13'h000,4'h0,32'h0, 0,0,13'h000,4'h0,32'h0, 0,0, 0,0,4'h0,13'h010,1,0,32'hDEADBEEF,0});
    vq.push_back('{1,1,13'h005,4'h2,32'h0000AB00, 0,0,13'h000,4'h0,32'h0, 0,0, 1,0,4'h2,13'h005,0,0,32'h0,0});
    vq.push_back('{0,0,13'h000,4'h0,32'h0, 1,0,13'h005,4'h0,32'h0, 0,0, 0,1,4'h0,13'h005,0,0,32'h0,0});
    vq.push_back('{0,0,13'h000,4'h0,32'h0, 0,0,13'h000,4'h0,32'h0, 0,0, 0,0,4'h0,13'h005,0,1,32'h1122AB44,0});
    vq.push_back('{1,0,13'h001,4'h0,32'h0, 1,0,13'h002,4'h0,32'h0, 0,0, 1,0,4'h0,13'h001,0,0,32'h0,0});
    vq.push_back('{0,0,13'h000,4'h0,32'h0, 0,0,13'h000,4'h0,32'h0, 0,0, 0,0,4'h0,13'h001,1,0,32'h10000001,0});
    vq.push_back('{0,0,13'h000,4'h0,32'h0, 1,1,13'h003,4'hF,32'hCAFEF00D, 0,0, 0,1,4'hF,13'h003,0,0,32'h0,0});
    vq.push_back('{1,0,13'h003,4'h0,32'h0, 0,0,13'h000,4'h0,32'h0, 0,0, 1,0,4'h0,13'h003,0,0,32'h0,0});
    vq.push_back('{0,0,13'h000,4'h0,32'h0, 0,0,13'h000,4'h0,32'h0, 0,0, 0,0,4'h0,13'h003,1,0,32'hCAFEF00D,0});
    vq.push_back('{1,0,13'h001,4'h0,32'h0, 0,0,13'h000,4'h0,32'h0, 0,0, 1,0,4'h0,13'h001,0,0,32'h0,0});
    vq.push_back('{0,0,13'h000,4'h0,32'h0, 1,0,13'h002,4'h0,32'h0, 0,0, 0,1,4'h0,13'h002,1,0,32'h10000001,0});
    vq.push_back('{0,0,13'h000,4'h0,32'h0, 0,0,13'h000,4'h0,32'h0, 0,0, 0,0,4'h0,13'h002,0,1,32'h10000002,0});
    vq.push_back('{1,0,13'h010,4'h0,32'h0, 1,1,13'h007,4'hF,32'h12345678, 0,0, 1,0,4'h0,13'h010,0,0,32'h0,0});
    vq.push_back('{0,0,13'h000,4'h0,32'h0, 0,0,13'h000,4'h0,32'h0, 0,0, 0,0,4'h0,13'h010,1,0,32'hDEADBEEF,0});

    // starvation limit: three full rounds of 8 m0 grants then 1 m1 grant
    add_contend(27);

    // lock while m0 streams: NORMAL accept, DRAIN, LOCKED, release
    vq.push_back('{1,0,13'h030,4'h0,32'h0, 0,0,13'h000,4'h0,32'h0, 0,0, 1,0,4'h0,13'h030,0,0,32'h0,0});
    vq.push_back('{1,0,13'h031,4'h0,32'h0, 0,0,13'h000,4'h0,32'h0, 1,0, 1,0,4'h0,13'h031,1,0,32'h10000030,0});
    vq.push_back('{1,0,13'h032,4'h0,32'h0, 0,0,13'h000,4'h0,32'h0, 1,0, 0,0,4'h0,13'h031,1,0,32'h10000031,0});
    vq.push_back('{1,0,13'h032,4'h0,32'h0, 1,0,13'h033,4'h0,32'h0, 1,0, 0,1,4'h0,13'h033,0,0,32'h0,1});
    vq.push_back('{1,0,13'h032,4'h0,32'h0, 0,0,13'h000,4'h0,32'h0, 1,0, 0,0,4'h0,13'h033,0,1,32'h10000033,1});
    vq.push_back('{1,0,13'h032,4'h0,32'h0, 0,0,13'h000,4'h0,32'h0, 0,0, 0,0,4'h0,13'h033,0,0,32'h0,1});
    vq.push_back('{1,0,13'h032,4'h0,32'h0, 0,0,13'h000,4'h0,32'h0, 0,0, 1,0,4'h0,13'h032,0,0,32'h0,0});
    vq.push_back('{0,0,13'h000,4'h0,32'h0, 0,0,13'h000,4'h0,32'h0, 0,0, 0,0,4'h0,13'h032,1,0,32'h10000032,0});

    // one-cycle lock pulse: DRAIN then back to NORMAL, never acknowledged
    vq.push_back('{0,0,13'h000,4'h0,32'h0, 1,0,13'h040,4'h0,32'h0, 1,0, 0,1,4'h0,13'h040,0,0,32'h0,0});
    vq.push_back('{0,0,13'h000,4'h0,32'h0, 1,0,13'h040,4'h0,32'h0, 0,0, 0,1,4'h0,13'h040,0,1,32'h10000040,0});
    vq.push_back('{1,0,13'h041,4'h0,32'h0, 1,0,13'h040,4'h0,32'h0, 0,0, 1,0,4'h0,13'h041,0,1,32'h10000040,0});
    vq.push_back('{0,0,13'h000,4'h0,32'h0, 1,0,13'h040,4'h0,32'h0, 0,0, 0,1,4'h0,13'h040,1,0,32'h10000041,0});
    vq.push_back('{0,0,13'h000,4'h0,32'h0, 0,0,13'h000,4'h0,32'h0, 0,0, 0,0,4'h0,13'h040,0,1,32'h10000040,0});

    // wait_cnt built up to 4, then reset: in-flight m0 read dropped, limit restarts at 0
    vq.push_back('{1,0,13'h050,4'h0,32'h0, 1,0,13'h051,4'h0,32'h0, 0,0, 1,0,4'h0,13'h050,0,0,32'h0,0});
    for (int i = 0; i < 3; i++)
      vq.push_back('{1,0,13'h050,4'h0,32'h0, 1,0,13'h051,4'h0,32'h0, 0,0, 1,0,4'h0,13'h050,1,0,32'h10000050,0});
    vq.push_back('{0,0,13'h000,4'h0,32'h0, 0,0,13'h000,4'h0,32'h0, 0,1, 0,0,4'h0,13'h000,0,0,32'h0,0});
    add_contend(9);

    // enter LOCKED, accept an m1 read, reset before its response arrives
    vq.push_back('{0,0,13'h000,4'h0,32'h0, 0,0,13'h000,4'h0,32'h0, 1,0, 0,0,4'h0,13'h021,0,0,32'h0,0});
    vq.push_back('{0,0,13'h000,4'h0,32'h0, 0,0,13'h000,4'h0,32'h0, 1,0, 0,0,4'h0,13'h021,0,0,32'h0,0});
    vq.push_back('{0,0,13'h000,4'h0,32'h0, 1,0,13'h060,4'h0,32'h0, 1,0, 0,1,4'h0,13'h060,0,0,32'h0,1});
    vq.push_back('{0,0,13'h000,4'h0,32'h0, 0,0,13'h000,4'h0,32'h0, 0,1, 0,0,4'h0,13'h000,0,0,32'h0,0});
    vq.push_back('{1,0,13'h061,4'h0,32'h0, 0,0,13'h000,4'h0,32'h0, 0,0, 1,0,4'h0,13'h061,0,0,32'h0,0});
    vq.push_back('{0,0,13'h000,4'h0,32'h0, 0,0,13'h000,4'h0,32'h0, 0,0, 0,0,4'h0,13'h061,1,0,32'h10000061,0});

    resetn      = 1'b0;
    lock_req    = 1'b0;
    m0_if.valid = 1'b0; m0_if.wr = 1'b0; m0_if.addr = '0; m0_if.be = '0; m0_if.wdata = '0;
    m1_if.valid = 1'b0; m1_if.wr = 1'b0; m1_if.addr = '0; m1_if.be = '0; m1_if.wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < vq.size(); i++)
      apply(i, vq[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data port of the RISC-V program/data RAM between two requesters: m0 (CPU dBus) and m1 (UART program loader / debug master).
- Fixed priority to m0, with a starvation limit that guarantees m1 progress.
- A lock handshake gives m1 exclusive access while the loader rewrites program memory.
- Sits between the dBus decode and the RAM data port; the RAM has a 1-cycle synchronous read.

Parameters:
- ADDR_WL, 13, word-address width of the RAM port
- DATA_WL, 32, data width
- NB_COL, 4, byte-enable columns (DATA_WL/8)
- MAX_WAIT, 8, consecutive m0 grants allowed while m1 is waiting (1..255)

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- m0_valid  in  1  m0 command valid
- m0_ready  out  1  m0 command accepted this cycle
- m0_wr  in  1  1=write, 0=read
- m0_addr  in  ADDR_WL  m0 word address
- m0_wdata  in  DATA_WL  m0 write data
- m0_be  in  NB_COL  m0 byte enables
- m0_rsp_valid  out  1  m0 read data valid
- m0_rdata  out  DATA_WL  m0 read data
- m1_valid, m1_ready, m1_wr, m1_addr, m1_wdata, m1_be, m1_rsp_valid, m1_rdata  same as m0, for m1
- lock_req  in  1  m1 requests exclusive access (level)
- lock_ack  out  1  exclusive access granted
- mem_addr  out  ADDR_WL  RAM data-port address
- mem_we  out  NB_COL  RAM byte write enables
- mem_din  out  DATA_WL  RAM write data
- mem_dout  in  DATA_WL  RAM read data (valid 1 cycle after address)

Behaviour:
- Reset (async, resetn=0):
  - state=NORMAL, wait_cnt=0, lock_ack=0.
  - m0_rsp_valid=m1_rsp_valid=0; the pending read tag is cleared.
  - Any in-flight read response is dropped, not delivered after reset.
- Winner W is selected combinationally each cycle:
  - Only one valid: that requester wins.
  - Both valid: m0 wins, unless wait_cnt==MAX_WAIT, in which case m1 wins.
  - In DRAIN or LOCKED, m0 is never eligible.
- Ready: mi_ready = mi_valid && (W==i). At most one ready per cycle. Ready never asserts without valid. Accept = valid && ready.
- Memory drive:
  - mem_addr and mem_din come from W.
  - mem_we = W.be when the accepted command is a write, else 0.
  - With no acceptance, mem_we=0 and mem_addr holds its last value.
- Read response:
  - An accepted read from requester i registers tag=i.
  - Next cycle: mi_rsp_valid=1 and mi_rdata=mem_dout. Latency is exactly 1 cycle, with no backpressure.
  - Writes produce no response.
  - Back-to-back reads, including alternating requesters, respond on consecutive cycles.
  - mi_rdata is don't-care when rsp_valid=0.
- wait_cnt (8-bit):
  - Increments when m0 is accepted while m1_valid=1, saturating at MAX_WAIT.
  - Clears when m1 is accepted or when m1_valid=0.
  - Ignored in LOCKED.
- State machine:
  - NORMAL: go to DRAIN when lock_req=1; m0 may still be accepted in that same cycle.
  - DRAIN (1 cycle): m0 is blocked, m1 may be accepted, and any m0 read response completes. Next state is LOCKED if lock_req=1, else NORMAL.
  - LOCKED: lock_ack=1 (registered, asserted on the first LOCKED cycle). Only m1 is served. Go to NORMAL when lock_req=0; lock_ack drops in the same cycle the state leaves LOCKED.
  - lock_req dropping during DRAIN returns to NORMAL and lock_ack never asserts.
- Simultaneous events:
  - A write from one requester and a read from the other in the same cycle cannot occur; only one command is accepted per cycle.
  - A same-address read after a write by the other requester returns the new data (the RAM is write-first on this port).

Test Plan:
- m0 reads addr 0x010 (RAM holds 0xDEADBEEF) with m1 idle → m0_ready in cycle 0, m0_rsp_valid=1 with m0_rdata=0xDEADBEEF in cycle 1, m1_rsp_valid stays 0.
- m0 and m1 both hold valid reads continuously, MAX_WAIT=8 → m0 granted 8 cycles, m1 granted on the 9th, pattern repeats; no cycle with both readies high.
- m0 write be=4'b0010 data 0x0000AB00 to addr 5, then m1 reads addr 5 → mem_we=4'b0010 for one cycle, m1_rdata byte1=0xAB with other bytes unchanged.
- lock_req rises while m0 streams reads → DRAIN for 1 cycle with the last m0 response delivered, lock_ack=1 the next cycle, m0_ready=0 throughout LOCKED; lock_req falls → lock_ack=0, m0 accepted again next cycle.
- resetn pulsed low in the cycle after an accepted m1 read → m1_rsp_valid stays 0, state NORMAL, wait_cnt=0, lock_ack=0.
- lock_req high for 1 cycle only → DRAIN then NORMAL, lock_ack never asserted, m1 traffic uninterrupted.
